// File: rtl/mem_nic_lsu.sv
// Load/store unit routing execute-stage requests to data memory or the NIC by address region.
// Define NIC_POLL_EN to serialise NIC stores behind a status-poll loop with timeout.
module mem_nic_lsu #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 16,
  parameter int NIC_ADDR_WIDTH = 2,
  parameter int MEM_LATENCY    = 1,
  parameter int POLL_LIMIT     = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_data,
  input  logic [4:0]                req_rd,
  input  logic [2:0]                req_ppp,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [31:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_d_out,
  input  logic [DATA_WIDTH-1:0]     mem_d_in,
  output logic                      nic_en,
  output logic                      nic_wr_en,
  output logic [NIC_ADDR_WIDTH-1:0] nic_addr,
  output logic [DATA_WIDTH-1:0]     nic_d_in,
  input  logic [DATA_WIDTH-1:0]     nic_d_out,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [2:0]                wb_ppp,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      nic_timeout,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, NIC_RD, POLL_RD, POLL_CHK, NIC_WR} state_t;

  state_t                 state, state_next;
  logic [MEM_LATENCY-1:0] sr_valid;
  logic [7:0]             sr_tag [MEM_LATENCY];
  logic [7:0]             nic_tag;
  logic                   nic_region;
  logic                   load_busy;
  logic                   accept;

  assign nic_region = (req_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
  assign load_busy  = |sr_valid;
  // NIC requests wait for the load pipe to drain so the two writeback sources never coincide.
  assign req_ready  = (state == IDLE) && !(nic_region && load_busy);
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE) || load_busy;

`ifdef NIC_POLL_EN
  localparam int POLL_CW = $clog2(POLL_LIMIT + 1);
  logic [NIC_ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0]     hold_data;
  logic [POLL_CW-1:0]        poll_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr <= '0;
      hold_data <= '0;
      poll_cnt  <= '0;
    end else if (accept && nic_region && req_store) begin
      hold_addr <= req_addr[NIC_ADDR_WIDTH-1:0];
      hold_data <= req_data;
      poll_cnt  <= '0;
    end else if (state == POLL_CHK && nic_d_out[0] && poll_cnt != POLL_CW'(POLL_LIMIT)) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next  = state;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_d_out   = '0;
    nic_en      = 1'b0;
    nic_wr_en   = 1'b0;
    nic_addr    = '0;
    nic_d_in    = '0;
    nic_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!nic_region) begin
            mem_en   = 1'b1;
            mem_addr = 32'(req_addr);
            if (req_store) begin
              mem_wr_en = 1'b1;
              mem_d_out = req_data;
            end
          end else if (!req_store) begin
            nic_en     = 1'b1;
            nic_addr   = req_addr[NIC_ADDR_WIDTH-1:0];
            state_next = NIC_RD;
          end else begin
`ifdef NIC_POLL_EN
            state_next = POLL_RD;
`else
            nic_en    = 1'b1;
            nic_wr_en = 1'b1;
            nic_addr  = req_addr[NIC_ADDR_WIDTH-1:0];
            nic_d_in  = req_data;
`endif
          end
        end
      end
      NIC_RD: state_next = IDLE;
`ifdef NIC_POLL_EN
      POLL_RD: begin
        nic_en     = 1'b1;
        nic_addr   = '1;
        state_next = POLL_CHK;
      end
      POLL_CHK: begin
        if (!nic_d_out[0]) begin
          state_next = NIC_WR;
        end else if (poll_cnt == POLL_CW'(POLL_LIMIT)) begin
          nic_timeout = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = POLL_RD;
        end
      end
      NIC_WR: begin
        nic_en     = 1'b1;
        nic_wr_en  = 1'b1;
        nic_addr   = hold_addr;
        nic_d_in   = hold_data;
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr_valid <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) sr_tag[i] <= '0;
      nic_tag  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_ppp   <= '0;
      wb_data  <= '0;
    end else begin
      state       <= state_next;
      sr_valid[0] <= accept && !nic_region && !req_store;
      sr_tag[0]   <= {req_rd, req_ppp};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
      end
      if (accept && nic_region && !req_store) nic_tag <= {req_rd, req_ppp};
      wb_valid <= sr_valid[MEM_LATENCY-1] || (state == NIC_RD);
      if (sr_valid[MEM_LATENCY-1]) begin
        {wb_rd, wb_ppp} <= sr_tag[MEM_LATENCY-1];
        wb_data         <= mem_d_in;
      end else if (state == NIC_RD) begin
        {wb_rd, wb_ppp} <= nic_tag;
        wb_data         <= nic_d_out;
      end
    end
  end

endmodule
